// File: rtl/myalu_mc.sv
// myalu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
// Most opcodes finish on the accept edge. Multiply (8) and divide (9) run
// bit-serially for NUMBITS cycles. Every output comes straight from a flop.
module myalu_mc #(
    parameter int NUMBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero,
    output logic               divzero
);
    localparam int CW = $clog2(NUMBITS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [NUMBITS-1:0]   b_q, b_d;
    // Working register. Multiply keeps {partial high, multiplier/low product}.
    // Divide keeps {remainder, dividend/quotient}.
    logic [2*NUMBITS-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUMBITS-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 dz_q, dz_d;

    logic [NUMBITS:0]     add_w, sub_w;
    logic [NUMBITS-1:0]   sc_res;
    logic                 sc_cy, sc_ovf, sc_dz;
    logic [NUMBITS:0]     mul_sum, div_trial, div_rem;
    logic                 div_ge;
    logic [2*NUMBITS-1:0] iter_next;

    // Single-cycle opcodes, evaluated on the raw inputs and captured only on accept.
    always_comb begin
        add_w  = {1'b0, A} + {1'b0, B};
        sub_w  = {1'b0, A} - {1'b0, B};
        sc_res = '0;
        sc_cy  = 1'b0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        case (opcode)
            4'd0: begin sc_res = add_w[NUMBITS-1:0]; sc_cy = add_w[NUMBITS]; end
            4'd1: begin
                sc_res = add_w[NUMBITS-1:0];
                sc_ovf = (A[NUMBITS-1] == B[NUMBITS-1]) && (add_w[NUMBITS-1] != A[NUMBITS-1]);
            end
            // The top bit of the widened difference is the borrow.
            4'd2: begin sc_res = sub_w[NUMBITS-1:0]; sc_cy = sub_w[NUMBITS]; end
            4'd3: begin
                sc_res = sub_w[NUMBITS-1:0];
                sc_ovf = (A[NUMBITS-1] != B[NUMBITS-1]) && (sub_w[NUMBITS-1] != A[NUMBITS-1]);
            end
            4'd4: sc_res = A & B;
            4'd5: sc_res = A | B;
            4'd6: sc_res = A ^ B;
            4'd7: sc_res = {1'b0, A[NUMBITS-1:1]};
            // This path is reached only when the divisor is zero.
            4'd9: begin sc_res = '1; sc_dz = 1'b1; end
            default: ;
        endcase
    end

    // One iteration step: shift-add multiply (op 8) or restoring divide (op 9).
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*NUMBITS-1:NUMBITS]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_trial = {acc_q[2*NUMBITS-1:NUMBITS], acc_q[NUMBITS-1]};
        div_ge    = div_trial >= {1'b0, b_q};
        div_rem   = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
        if (op_q[0])
            iter_next = {div_rem[NUMBITS-1:0], acc_q[NUMBITS-2:0], div_ge};
        else
            iter_next = {mul_sum, acc_q[NUMBITS-1:1]};
    end

    // Control FSM: accept in IDLE, iterate in BUSY, hold results in DONE until handshake.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d  = opcode;
                b_d   = B;
                acc_d = {{NUMBITS{1'b0}}, A};
                cnt_d = CW'(NUMBITS);
                if (opcode == 4'd8 || (opcode == 4'd9 && B != '0)) begin
                    state_d = BUSY;
                end else begin
                    state_d  = DONE;
                    result_d = sc_res;
                    carry_d  = sc_cy;
                    ovf_d    = sc_ovf;
                    dz_d     = sc_dz;
                    zero_d   = (sc_res == '0);
                end
            end
            BUSY: begin
                acc_d = iter_next;
                cnt_d = cnt_q - CW'(1);
                // The last iteration result is captured directly on its own edge.
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    result_d = iter_next[NUMBITS-1:0];
                    carry_d  = !op_q[0] && (iter_next[2*NUMBITS-1:NUMBITS] != '0);
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                    zero_d   = (iter_next[NUMBITS-1:0] == '0);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset discards any operation that is in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carryout  = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign divzero   = dz_q;
endmodule

// File: tb/tb_myalu_mc.sv
// tb_myalu_mc: directed and random checks of myalu_mc at NUMBITS = 8
// against an integer-arithmetic reference model.
module tb_myalu_mc;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [3:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] result;
    logic         carryout, overflow, zero, divzero;

    int errs = 0;
    int checks = 0;

    myalu_mc #(.NUMBITS(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carryout(carryout), .overflow(overflow), .zero(zero),
        .divzero(divzero)
    );

    always #5 clk = ~clk;

    // Reference model built from plain integer arithmetic. Returns {divzero, overflow, carry, result}.
    function automatic logic [10:0] model(input int a, input int b, input int op);
        int  r, s, sa, sb;
        bit  cy, ov, dz;
        cy = 0; ov = 0; dz = 0; r = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            0: begin r = a + b; cy = (r > 255); end
            1: begin s = sa + sb; r = s; ov = (s > 127 || s < -128); end
            2: begin r = a - b; cy = (a < b); end
            3: begin s = sa - sb; r = s; ov = (s > 127 || s < -128); end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = a / 2;
            8: begin r = a * b; cy = ((a * b) / 256) != 0; end
            9: if (b == 0) begin r = 255; dz = 1; end else r = a / b;
            default: r = 0;
        endcase
        return {dz, ov, cy, r[7:0]};
    endfunction

    function automatic int exp_lat(input int b, input int op);
        return (op == 8 || (op == 9 && b != 0)) ? N + 1 : 1;
    endfunction

    // Issue one request and wait for out_valid. lat counts cycles from the accept cycle.
    // rdy_seen records whether in_ready was high while the operation ran.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output int lat, output bit rdy_seen);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        A = a; B = b; opcode = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = N'($urandom); B = N'($urandom); opcode = 4'($urandom);
        lat = 1; rdy_seen = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({result, carryout, overflow, divzero} !== 11'd0) begin errs++; $display("FAIL reset_outputs got %h exp 0", {result, carryout, overflow, divzero}); end
        checks++; if (zero !== 1'b1) begin errs++; $display("FAIL reset_zero got %b exp 1", zero); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [7:0] ta[8], tb_[8], tr[8];
        logic [3:0] to[8];
        logic       tc[8], tv[8], td[8];
        int         tl[8];
        int         lat;
        bit         rs;
        ta = '{8'hFF, 8'h7F, 8'h80, 8'h28, 8'h60, 8'h10, 8'h64, 8'h55};
        tb_ = '{8'h01, 8'h01, 8'h01, 8'h91, 8'h00, 8'h20, 8'h07, 8'h00};
        to = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd8, 4'd9, 4'd9};
        tr = '{8'h00, 8'h80, 8'h7F, 8'h97, 8'h30, 8'h00, 8'h0E, 8'hFF};
        tc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        td = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tl = '{1, 1, 1, 1, 1, 9, 9, 1};
        for (int i = 0; i < 8; i++) begin
            do_op(ta[i], tb_[i], to[i], lat, rs);
            checks++; if (lat !== tl[i]) begin errs++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, tl[i]); end
            checks++; if (result !== tr[i]) begin errs++; $display("FAIL dir%0d_result got %h exp %h", i, result, tr[i]); end
            checks++; if ({carryout, overflow, divzero} !== {tc[i], tv[i], td[i]}) begin errs++; $display("FAIL dir%0d_flags got %b exp %b", i, {carryout, overflow, divzero}, {tc[i], tv[i], td[i]}); end
            checks++; if (zero !== (tr[i] == 8'h00)) begin errs++; $display("FAIL dir%0d_zero got %b exp %b", i, zero, tr[i] == 8'h00); end
            checks++; if (rs !== 1'b0) begin errs++; $display("FAIL dir%0d_in_ready_busy got %b exp 0", i, rs); end
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [3:0]  op;
        logic [10:0] e;
        int          lat;
        bit          rs;
        for (int i = 0; i < 60; i++) begin
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            op = 4'($urandom);
            e  = model(a, b, op);
            do_op(a, b, op, lat, rs);
            checks++; if (lat !== exp_lat(b, op)) begin errs++; $display("FAIL rnd%0d_latency op=%0d got %0d exp %0d", i, op, lat, exp_lat(b, op)); end
            checks++; if ({divzero, overflow, carryout, result} !== e) begin errs++; $display("FAIL rnd%0d_out op=%0d a=%h b=%h got %h exp %h", i, op, a, b, {divzero, overflow, carryout, result}, e); end
            checks++; if (zero !== (e[7:0] == 8'h00)) begin errs++; $display("FAIL rnd%0d_zero got %b exp %b", i, zero, e[7:0] == 8'h00); end
        end
    endtask

    task automatic test_reset_busy();
        bit bad;
        @(posedge clk); #1;
        A = 8'h64; B = 8'h07; opcode = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstbusy_out_valid_async got %b exp 0", out_valid); end
        @(negedge clk); reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin errs++; $display("FAIL rstbusy_out_valid_after got 1 exp 0"); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rstbusy_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_backpressure();
        int  lat;
        bit  rs, bad;
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, 4'd0, lat, rs);
        checks++; if (result !== 8'h46) begin errs++; $display("FAIL bp_result got %h exp 46", result); end
        A = 8'hF0; B = 8'h20; opcode = 4'd0; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || result !== 8'h46 || carryout || overflow || zero || divzero) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin errs++; $display("FAIL bp_hold got changed exp stable result 46"); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL bp_handshake got %b exp 01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if ({out_valid, result, carryout} !== {1'b1, 8'h10, 1'b1}) begin errs++; $display("FAIL bp_next got %h exp 110", {out_valid, result, carryout}); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit rs;
        do_op(8'h01, 8'h02, 4'd0, lat, rs);
        A = 8'h3C; B = 8'h0F; opcode = 4'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL b2b_no_overlap got %b exp 01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if ({out_valid, result} !== {1'b1, 8'h0C}) begin errs++; $display("FAIL b2b_result got %h exp 10c", {out_valid, result}); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_busy();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
